// File: rtl/lcd_forward_rct_if.sv
// Pixel stream interface for the forward RCT encoder: RGB pixels in, Y/Cb/Cr pairs out.
// The master drives the pixel side and the sink ready. The slave (the encoder) drives the pair side.
interface lcd_forward_rct_if #(
    parameter int IMG_PIX_W  = 8,
    parameter int WAVE_PIX_W = 10
);
    logic                         in_valid;
    logic                         in_ready;
    logic                         in_last;
    logic [IMG_PIX_W-1:0]         r;
    logic [IMG_PIX_W-1:0]         g;
    logic [IMG_PIX_W-1:0]         b;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [WAVE_PIX_W-1:0] y0;
    logic signed [WAVE_PIX_W-1:0] cb0;
    logic signed [WAVE_PIX_W-1:0] cr0;
    logic signed [WAVE_PIX_W-1:0] y1;
    logic signed [WAVE_PIX_W-1:0] cb1;
    logic signed [WAVE_PIX_W-1:0] cr1;
    logic                         out_last;
    logic                         out_pad;

    modport master (
        output in_valid, in_last, r, g, b, out_ready,
        input  in_ready, out_valid, y0, cb0, cr0, y1, cb1, cr1, out_last, out_pad
    );

    modport slave (
        input  in_valid, in_last, r, g, b, out_ready,
        output in_ready, out_valid, y0, cb0, cr0, y1, cb1, cr1, out_last, out_pad
    );
endinterface

// File: rtl/lcd_forward_rct.sv
// Forward reversible colour transform: converts RGB pixels to Y/Cb/Cr and pairs them for the frame buffer.
// Handshake: a beat moves when valid && ready. in_ready = !out_valid || out_ready, and it never looks at in_valid.
module lcd_forward_rct #(
    parameter int IMG_PIX_W  = 8,
    parameter int WAVE_PIX_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    lcd_forward_rct_if.slave  bus,
    output logic              dbg_state
);
    typedef enum logic {EVEN = 1'b0, ODD = 1'b1} state_t;

    localparam int SW = WAVE_PIX_W + 1;

    state_t                  state_q, state_d;
    logic [SW-1:0]           sum;
    logic [WAVE_PIX_W-1:0]   cur_y, cur_cb, cur_cr;
    logic [WAVE_PIX_W-1:0]   hold_y, hold_cb, hold_cr;
    logic [WAVE_PIX_W-1:0]   p0_y, p0_cb, p0_cr;
    logic [WAVE_PIX_W-1:0]   y0_q, cb0_q, cr0_q, y1_q, cb1_q, cr1_q;
    logic                    out_valid_q, out_last_q, out_pad_q;
    logic                    in_xfer, out_xfer, hold_load, pair_load, pair_pad;

    // The sum is one bit wider than the samples so the carry survives the shift.
    assign sum    = SW'(bus.r) + (SW'(bus.g) << 1) + SW'(bus.b);
    assign cur_y  = WAVE_PIX_W'(sum >> 2);
    assign cur_cb = WAVE_PIX_W'(bus.b) - WAVE_PIX_W'(bus.g);
    assign cur_cr = WAVE_PIX_W'(bus.r) - WAVE_PIX_W'(bus.g);

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign in_xfer      = bus.in_valid && bus.in_ready;
    assign out_xfer     = out_valid_q && bus.out_ready;
    assign dbg_state    = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EVEN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        hold_load = 1'b0;
        pair_load = 1'b0;
        pair_pad  = 1'b0;
        p0_y      = cur_y;
        p0_cb     = cur_cb;
        p0_cr     = cur_cr;
        if (in_xfer) begin
            case (state_q)
                EVEN: begin
                    if (bus.in_last) begin
                        // Odd-length line: the lone pixel is duplicated into both slots.
                        pair_load = 1'b1;
                        pair_pad  = 1'b1;
                    end else begin
                        hold_load = 1'b1;
                        state_d   = ODD;
                    end
                end
                ODD: begin
                    pair_load = 1'b1;
                    p0_y      = hold_y;
                    p0_cb     = hold_cb;
                    p0_cr     = hold_cr;
                    state_d   = EVEN;
                end
                default: state_d = EVEN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_y  <= '0;
            hold_cb <= '0;
            hold_cr <= '0;
        end else if (hold_load) begin
            hold_y  <= cur_y;
            hold_cb <= cur_cb;
            hold_cr <= cur_cr;
        end
    end

    // A new pair may load in the same cycle the old one leaves, so the sink sees one pair per two pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_pad_q   <= 1'b0;
            y0_q        <= '0;
            cb0_q       <= '0;
            cr0_q       <= '0;
            y1_q        <= '0;
            cb1_q       <= '0;
            cr1_q       <= '0;
        end else if (pair_load) begin
            out_valid_q <= 1'b1;
            out_last_q  <= bus.in_last;
            out_pad_q   <= pair_pad;
            y0_q        <= p0_y;
            cb0_q       <= p0_cb;
            cr0_q       <= p0_cr;
            y1_q        <= cur_y;
            cb1_q       <= cur_cb;
            cr1_q       <= cur_cr;
        end else if (out_xfer) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_pad_q   <= 1'b0;
            y0_q        <= '0;
            cb0_q       <= '0;
            cr0_q       <= '0;
            y1_q        <= '0;
            cb1_q       <= '0;
            cr1_q       <= '0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_pad   = out_pad_q;
    assign bus.y0        = y0_q;
    assign bus.cb0       = cb0_q;
    assign bus.cr0       = cr0_q;
    assign bus.y1        = y1_q;
    assign bus.cb1       = cb1_q;
    assign bus.cr1       = cr1_q;
endmodule
